uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first.
// Bytes written on wr_en/wr_data are queued in a small FIFO and shifted out on
// tx. Each bit lasts 16 ticks of an internal 16x-oversample tick (tick16).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the data bits and the stop bit (176-tick frame instead of 160).
module uart_tx_fifo #(
   parameter int unsigned TICK_DIV   = 27,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       overflow,
   output logic       tick16,
   output logic       tx
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [3:0]    BIT_LAST  = 4'd15;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;
`endif

   // ---------------------------------------------------------------------
   // 16x tick generator
   // ---------------------------------------------------------------------
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick_w;

   assign tick_w = (tick_cnt_q == TICK_LAST);

   // Next tick count: free-running 0..TICK_DIV-1, independent of the FSM.
   always_comb begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      if (tick_w) begin
         tick_cnt_d = '0;
      end
   end

   // Tick counter register.
   always_ff @(posedge clk) begin
      if (Rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q, overflow_q;
   logic          push, pop;
   logic [7:0]    head;

   state_t        state_q;
   logic [3:0]    bit_tick_q;

   assign push = wr_en && !full_q;
   assign head = mem_q[rptr_q];

   // Pops happen only on a tick, only with data present, and only when a new
   // frame may begin: from IDLE, or at the last tick of the stop bit.
   assign pop  = tick_w && !empty_q &&
                 ((state_q == IDLE) ||
                  ((state_q == STOP) && (bit_tick_q == BIT_LAST)));

   // Next occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, registered flags and sticky overflow.
   always_ff @(posedge clk) begin
      if (Rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wptr_q <= wptr_q + AW'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
         if (wr_en && full_q) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !Rst) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------
   // Transmit FSM
   // ---------------------------------------------------------------------
   logic [2:0] idx_q;
   logic [7:0] shreg_q;
   logic       tx_q;
   logic       busy_q;
`ifdef UART_TX_PARITY_EN
   logic       par_q;
`endif

   // Frame sequencer: advances only on ticks, drives the registered tx/busy.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         bit_tick_q <= '0;
         idx_q      <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else if (tick_w) begin
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q    <= head;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  bit_tick_q <= '0;
                  state_q    <= START;
`ifdef UART_TX_PARITY_EN
                  par_q      <= ^head;
`endif
               end
            end

            START: begin
               if (bit_tick_q == BIT_LAST) begin
                  bit_tick_q <= '0;
                  idx_q      <= '0;
                  tx_q       <= shreg_q[0];
                  state_q    <= DATA;
               end else begin
                  bit_tick_q <= bit_tick_q + 4'd1;
               end
            end

            DATA: begin
               if (bit_tick_q == BIT_LAST) begin
                  bit_tick_q <= '0;
                  if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx_q    <= par_q;
                     state_q <= PARITY;
`else
                     tx_q    <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     // Drive the next bit straight from the pre-shift value so
                     // tx and the shift register move on the same tick.
                     shreg_q <= {1'b0, shreg_q[7:1]};
                     tx_q    <= shreg_q[1];
                     idx_q   <= idx_q + 3'd1;
                  end
               end else begin
                  bit_tick_q <= bit_tick_q + 4'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick_q == BIT_LAST) begin
                  bit_tick_q <= '0;
                  tx_q       <= 1'b1;
                  state_q    <= STOP;
               end else begin
                  bit_tick_q <= bit_tick_q + 4'd1;
               end
            end
`endif

            STOP: begin
               if (bit_tick_q == BIT_LAST) begin
                  bit_tick_q <= '0;
                  if (pop) begin
                     // Back-to-back frame: start bit follows stop with no gap.
                     shreg_q <= head;
                     tx_q    <= 1'b0;
                     state_q <= START;
`ifdef UART_TX_PARITY_EN
                     par_q   <= ^head;
`endif
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else begin
                  bit_tick_q <= bit_tick_q + 4'd1;
               end
            end

            default: begin
               state_q    <= IDLE;
               bit_tick_q <= '0;
               tx_q       <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;
   assign tick16   = tick_w;
   assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at TICK_DIV=4 (64 clk/bit).
module tb_uart_tx_fifo;

   localparam int unsigned TD = 4;
   localparam int unsigned FD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FB = 11;
   localparam int unsigned FL = 704;
   localparam logic [10:0] FRAME_A5 = 11'h54A;   // stop,par=0,A5,start
`else
   localparam int unsigned FB = 10;
   localparam int unsigned FL = 640;
   localparam logic [9:0]  FRAME_A5 = 10'h34A;   // stop,A5,start
`endif

   logic       clk = 1'b0;
   logic       Rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty, busy, overflow, tick16, tx;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   logic [7:0]  rb   [5];
   logic        rok  [5];
   int unsigned rgap [5];
   logic [7:0]  exp2 [5] = '{8'h11, 8'h00, 8'h01, 8'hFF, 8'h80};
   logic [7:0]  exp5 [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};

   uart_tx_fifo #(
      .TICK_DIV   (TD),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk      (clk),
      .Rst      (Rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .overflow (overflow),
      .tick16   (tick16),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Present one byte for one cycle, then scramble wr_data.
   task automatic wr_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en   = 1'b0;
      wr_data = ~b;
   endtask

   task automatic wait_busy(output logic ok, output int unsigned n);
      n = 0;
      while (busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = (busy === 1'b1);
   endtask

   task automatic wait_cyc(input int unsigned target);
      int unsigned guard = 0;
      while (cyc != target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cyc_reached", cyc, target);
   endtask

   // Write one byte from idle and capture the whole frame mid-bit.
   task automatic capture_frame(input logic [7:0] b, output logic [FB-1:0] f,
                                output int unsigned len, output int unsigned lat);
      logic ok;
      f   = '0;
      len = 0;
      wr_byte(b);
      wait_busy(ok, lat);
      check("frame_busy_rise", ok, 1'b1);
      if (!ok) return;
      check("frame_tx_low_with_busy", tx, 1'b0);
      while (busy === 1'b1 && len < 2000) begin
         if ((len % 64) == 32 && (len / 64) < FB) f[len / 64] = tx;
         @(negedge clk);
         len++;
      end
   endtask

   // 16x-style receiver: find the start edge, sample each bit at its middle.
   task automatic rx_byte(output logic [7:0] d, output logic ok, output int unsigned gap);
      logic [FB-1:0] f;
      gap = 0;
      ok  = 1'b0;
      d   = '0;
      f   = '0;
      while (tx !== 1'b0 && gap < 3000) begin
         @(negedge clk);
         gap++;
      end
      if (tx !== 1'b0) return;
      for (int k = 0; k < int'(FB); k++) begin
         repeat ((k == 0) ? 32 : 64) @(negedge clk);
         f[k] = tx;
      end
      d  = f[8:1];
      ok = (f[0] == 1'b0) && (f[FB-1] == 1'b1);
`ifdef UART_TX_PARITY_EN
      ok = ok && (f[9] == ^f[8:1]);
`endif
   endtask

   logic [FB-1:0] frame;
   int unsigned   flen, lat, c0, lows, bhigh;
   logic          okb;
   logic [31:0]   word;

   initial begin
      Rst     = 1'b1;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_full", full, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_overflow", overflow, 1'b0);
      check("rst_tick16", tick16, 1'b0);
      Rst = 1'b0;
      @(negedge clk);

      // Test 1: single 0xA5 frame.
      capture_frame(8'hA5, frame, flen, lat);
      check("t1_latency_le_td1", (lat >= 1 && lat <= TD + 1), 1'b1);
      check("t1_frame_bits", frame, FRAME_A5);
      check("t1_busy_cycles", flen, FL);
      check("t1_empty_after", empty, 1'b1);
      check("t1_busy_after", busy, 1'b0);
      repeat (10) @(negedge clk);

      // Test 2: burst while in flight, overflow, back-to-back frames.
      fork
         begin
            for (int j = 0; j < 5; j++) rx_byte(rb[j], rok[j], rgap[j]);
         end
         begin
            wr_byte(8'h11);
            wait_busy(okb, lat);
            check("t2_busy", okb, 1'b1);
            wr_en = 1'b1;
            wr_data = 8'h00; @(negedge clk);
            wr_data = 8'h01; @(negedge clk);
            wr_data = 8'hFF; @(negedge clk);
            check("t2_not_full_at3", full, 1'b0);
            wr_data = 8'h80; @(negedge clk);
            check("t2_full_at4", full, 1'b1);
            wr_data = 8'h3C; @(negedge clk);
            wr_en = 1'b0;
            wr_data = 8'h5A;
            check("t2_overflow_set", overflow, 1'b1);
         end
      join
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t2_byte%0d", j), rb[j], exp2[j]);
         check($sformatf("t2_frame_ok%0d", j), rok[j], 1'b1);
         if (j > 0) check($sformatf("t2_gap%0d", j), rgap[j], 32);
      end
      repeat (40) @(negedge clk);
      check("t2_idle_busy", busy, 1'b0);
      check("t2_idle_empty", empty, 1'b1);
      check("t2_overflow_sticky", overflow, 1'b1);

      // Test 3: 0x00000100 as little-endian bytes.
      fork
         begin
            for (int j = 0; j < 4; j++) rx_byte(rb[j], rok[j], rgap[j]);
         end
         begin
            wr_en = 1'b1;
            wr_data = 8'h00; @(negedge clk);
            wr_data = 8'h01; @(negedge clk);
            wr_data = 8'h00; @(negedge clk);
            wr_data = 8'h00; @(negedge clk);
            wr_en = 1'b0;
            wr_data = 8'hEE;
         end
      join
      word = {rb[3], rb[2], rb[1], rb[0]};
      check("t3_word", word, 32'h0000_0100);
      for (int j = 0; j < 4; j++) check($sformatf("t3_frame_ok%0d", j), rok[j], 1'b1);
      check("t3_gap3", rgap[3], 32);
      repeat (40) @(negedge clk);

      // Test 5: push coinciding with the STOP->START pop at count=DEPTH-1.
      fork
         begin
            for (int j = 0; j < 5; j++) rx_byte(rb[j], rok[j], rgap[j]);
         end
         begin
            wr_byte(8'h21);
            wait_busy(okb, lat);
            check("t5_busy", okb, 1'b1);
            c0 = cyc;
            wr_en = 1'b1;
            wr_data = 8'h22; @(negedge clk);
            wr_data = 8'h23; @(negedge clk);
            wr_data = 8'h24; @(negedge clk);
            wr_en = 1'b0;
            wait_cyc(c0 + FL - 1);
            check("t5_tick_at_pop", tick16, 1'b1);
            check("t5_full_before", full, 1'b0);
            wr_en = 1'b1;
            wr_data = 8'h25;
            @(negedge clk);
            wr_en = 1'b0;
            wr_data = 8'h00;
            check("t5_full_after", full, 1'b0);
            check("t5_empty_after", empty, 1'b0);
            check("t5_tx_start", tx, 1'b0);
         end
      join
      for (int j = 0; j < 5; j++) begin
         check($sformatf("t5_byte%0d", j), rb[j], exp5[j]);
         check($sformatf("t5_frame_ok%0d", j), rok[j], 1'b1);
      end
      repeat (40) @(negedge clk);

      // Test 4: reset during data bit 3 of 0x5A with two bytes queued.
      wr_byte(8'h5A);
      wait_busy(okb, lat);
      check("t4_busy", okb, 1'b1);
      c0 = cyc;
      wr_byte(8'h11);
      wr_byte(8'h22);
      wait_cyc(c0 + 288);
      check("t4_bit3_value", tx, 1'b1);
      check("t4_busy_before", busy, 1'b1);
      check("t4_empty_before", empty, 1'b0);
      Rst = 1'b1;
      @(negedge clk);
      check("t4_rst_tx", tx, 1'b1);
      check("t4_rst_busy", busy, 1'b0);
      check("t4_rst_empty", empty, 1'b1);
      check("t4_rst_full", full, 1'b0);
      check("t4_rst_overflow", overflow, 1'b0);
      Rst = 1'b0;
      lows  = 0;
      bhigh = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) bhigh++;
      end
      check("t4_tx_low_cycles", lows, 0);
      check("t4_busy_cycles", bhigh, 0);

`ifdef UART_TX_PARITY_EN
      // Test 6: parity bit values and frame length.
      capture_frame(8'h07, frame, flen, lat);
      check("t6_frame_07", frame, 11'h60E);
      check("t6_len_07", flen, 704);
      repeat (10) @(negedge clk);
      capture_frame(8'h03, frame, flen, lat);
      check("t6_frame_03", frame, 11'h406);
      check("t6_len_03", flen, 704);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
